// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage of the 8-bit processor.
// It accepts the execute-stage bundle and runs loads/stores against data
// memory over a req/ack handshake, stalling upstream while one is open.
// It turns jumps into a one-cycle pc_load pulse and registers the
// write-back bundle for the next stage.
// Optional feature: define MEM_TIMEOUT_EN to abort a transaction that has
// not been acked within TIMEOUT_CYCLES WAIT cycles and raise sticky mem_err.
//
// Memory handshake: mem_req rises the cycle after a memory bundle is
// accepted. mem_we, mem_addr and mem_wdata are stable for as long as mem_req
// is high. The transaction completes on the rising edge where mem_req=1 and
// mem_ack=1 are sampled together; mem_rdata must be valid in that cycle.
// mem_ack may already be high in the first mem_req cycle. mem_ack is ignored
// while no request is open. A reset may drop mem_req mid-transaction.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       valid_in,
  input  logic       WRMem,
  input  logic       WMMem,
  input  logic       RMMem,
  input  logic       NEQMem,
  input  logic       JMem,
  input  logic       JCMem,
  input  logic       zeroOut,
  input  logic [7:0] acOutValue,
  input  logic [7:0] ulaJumpOut,
  input  logic [7:0] rs,
  input  logic [1:0] rdOut,
  output logic       stall_o,
  output logic       pc_load,
  output logic [7:0] pc_target,
  output logic       mem_req,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ack,
  output logic       wb_valid,
  output logic       wb_wr,
  output logic [1:0] wb_rd,
  output logic [7:0] wb_data,
  output logic       mem_err,
  output logic       dbg_state
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_WAIT = 1'b1;

  // The counter is 8 bits wide, so the limit must fit in 1..255.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mem_stage: TIMEOUT_CYCLES must be in 1..255");
  end

  logic       state_q, state_d;
  logic       mem_req_q, mem_req_d;
  logic       mem_we_q, mem_we_d;
  logic [7:0] mem_addr_q, mem_addr_d;
  logic [7:0] mem_wdata_q, mem_wdata_d;
  logic       pc_load_q, pc_load_d;
  logic [7:0] pc_target_q, pc_target_d;
  logic       wb_valid_q, wb_valid_d;
  logic       wb_wr_q, wb_wr_d;
  logic [1:0] wb_rd_q, wb_rd_d;
  logic [7:0] wb_data_q, wb_data_d;
  // Bundle fields kept across WAIT; the saved ALU result lives in mem_addr_q.
  logic [1:0] sv_rd_q, sv_rd_d;
  logic       sv_wr_q, sv_wr_d;
  logic       sv_load_q, sv_load_d;

  logic is_mem;
  logic taken;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       mem_err_q, mem_err_d;
`endif

  assign is_mem = RMMem | WMMem;
  // NEQMem selects the polarity: 0 jumps on zero, 1 jumps on non-zero.
  assign taken  = JMem | (JCMem & (zeroOut ^ NEQMem));

  // Next-state and output-register logic for the IDLE/WAIT controller.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    pc_load_d   = 1'b0;
    pc_target_d = pc_target_q;
    wb_valid_d  = 1'b0;
    wb_wr_d     = wb_wr_q;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    sv_rd_d     = sv_rd_q;
    sv_wr_d     = sv_wr_q;
    sv_load_d   = sv_load_q;
`ifdef MEM_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    mem_err_d   = mem_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (valid_in) begin
          if (taken) begin
            pc_load_d   = 1'b1;
            pc_target_d = ulaJumpOut;
          end
          if (is_mem) begin
            state_d     = ST_WAIT;
            mem_req_d   = 1'b1;
            mem_we_d    = WMMem;
            mem_addr_d  = acOutValue;
            mem_wdata_d = rs;
            sv_rd_d     = rdOut;
            sv_wr_d     = WRMem;
            // A bundle with both read and write set is a plain store.
            sv_load_d   = ~WMMem;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt_d   = 8'd0;
`endif
          end else begin
            wb_valid_d = 1'b1;
            wb_wr_d    = WRMem;
            wb_rd_d    = rdOut;
            wb_data_d  = acOutValue;
          end
        end
      end
      ST_WAIT: begin
        if (mem_ack) begin
          state_d    = ST_IDLE;
          mem_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_wr_d    = sv_wr_q;
          wb_rd_d    = sv_rd_q;
          wb_data_d  = sv_load_q ? mem_rdata : mem_addr_q;
        end
`ifdef MEM_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          // Abort: retire the bundle without a register write and flag it.
          state_d    = ST_IDLE;
          mem_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_wr_d    = 1'b0;
          wb_rd_d    = sv_rd_q;
          mem_err_d  = 1'b1;
          tmo_cnt_d  = tmo_cnt_q + 8'd1;
        end else begin
          tmo_cnt_d  = tmo_cnt_q + 8'd1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 8'h00;
      mem_wdata_q <= 8'h00;
      pc_load_q   <= 1'b0;
      pc_target_q <= 8'h00;
      wb_valid_q  <= 1'b0;
      wb_wr_q     <= 1'b0;
      wb_rd_q     <= 2'd0;
      wb_data_q   <= 8'h00;
      sv_rd_q     <= 2'd0;
      sv_wr_q     <= 1'b0;
      sv_load_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      pc_load_q   <= pc_load_d;
      pc_target_q <= pc_target_d;
      wb_valid_q  <= wb_valid_d;
      wb_wr_q     <= wb_wr_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      sv_rd_q     <= sv_rd_d;
      sv_wr_q     <= sv_wr_d;
      sv_load_q   <= sv_load_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  // Timeout counter and sticky error flag; mem_err clears only on reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q <= 8'd0;
      mem_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      mem_err_q <= mem_err_d;
    end
  end
  assign mem_err = mem_err_q;
`else
  assign mem_err = 1'b0;
`endif

  // Upstream holds while a memory bundle is offered or a request is open.
  assign stall_o = ((state_q == ST_IDLE) & valid_in & is_mem) |
                   ((state_q == ST_WAIT) & ~mem_ack);

  assign pc_load   = pc_load_q;
  assign pc_target = pc_target_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_wr     = wb_wr_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign dbg_state = state_q;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage of the 8-bit processor, sitting directly after the execute stage and consuming its stage-crossing signals (ALU result, zero flag, jump target, register value, destination register and the *Mem control bits). It does three things:
- performs load/store transactions against the data memory through a req/ack handshake, stalling upstream while a transaction is outstanding;
- resolves unconditional and conditional jumps into a one-cycle PC-load pulse;
- registers the write-back bundle for the following stage.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles to wait for mem_ack before aborting. Used only with MEM_TIMEOUT_EN.

Ports:
- clock  in  1  single rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- valid_in  in  1  execute-stage bundle is valid this cycle.
- WRMem, WMMem, RMMem, NEQMem, JMem, JCMem  in  1 each  register-write, memory-write, memory-read, not-equal select, jump, conditional-jump.
- zeroOut  in  1  ALU zero flag.
- acOutValue  in  8  ALU result. Used as the memory address and as write-back data for non-loads.
- ulaJumpOut  in  8  jump target (PC + immediate).
- rs  in  8  store data.
- rdOut  in  2  destination register.
- stall_o  out  1  upstream must hold its bundle.
- pc_load  out  1  one-cycle pulse: load pc_target.
- pc_target  out  8  jump target.
- mem_req, mem_we  out  1  memory request, write enable.
- mem_addr, mem_wdata  out  8  address, store data.
- mem_rdata  in  8  load data, valid with mem_ack.
- mem_ack  in  1  transaction complete.
- wb_valid, wb_wr  out  1  write-back bundle valid, register write enable.
- wb_rd  out  2  write-back register.
- wb_data  out  8  write-back value.
- mem_err  out  1  sticky timeout flag. Tied 0 without MEM_TIMEOUT_EN.

## Operation
The FSM has two states, IDLE and WAIT.

- **IDLE.** The incoming bundle is accepted on the rising edge when valid_in=1.
  - Non-memory bundle (RMMem=WMMem=0): wb_valid=1, wb_wr=WRMem, wb_rd=rdOut, wb_data=acOutValue are registered at that edge. The state stays IDLE.
  - Memory bundle (RMMem|WMMem): at the same edge, register mem_req=1, mem_addr=acOutValue, mem_wdata=rs, mem_we=WMMem, and save rdOut and WRMem. Go to WAIT.
  - If RMMem=WMMem=1, the bundle is a store only; the read is ignored. Write-back data is acOutValue.
- **WAIT.**
  - mem_req, mem_we, mem_addr and mem_wdata are held stable until mem_ack=1 is sampled.
  - On ack, go to IDLE and drop mem_req at that edge. Also register the write-back bundle: wb_data=mem_rdata for loads, acOutValue (saved) for stores; wb_wr=saved WRMem.
  - In WAIT, valid_in is ignored.
- **stall_o** (combinational) = (IDLE & valid_in & (RMMem|WMMem)) | (WAIT & ~mem_ack). The execute stage therefore holds exactly until the ack cycle.
- **Jump resolution** happens at bundle acceptance, independent of the memory op.
  - taken = JMem | (JCMem & (zeroOut ^ NEQMem)): NEQMem=0 jumps on zero, NEQMem=1 jumps on non-zero.
  - If taken, register pc_load=1 and pc_target=ulaJumpOut for one cycle. pc_target holds its value afterwards.
- **Registered pulses.** wb_valid and pc_load are single-cycle pulses. The other outputs hold their last value.

## Timing
- **Reset.** reset_n=0 asynchronously forces:
  - state=IDLE;
  - mem_req, mem_we, pc_load, wb_valid, wb_wr, mem_err = 0;
  - mem_addr, mem_wdata, pc_target, wb_data = 0x00;
  - wb_rd = 0.
  
  A reset during WAIT abandons the transaction: mem_req falls immediately, and the memory must tolerate this.
- **Non-memory latency.** wb_valid one cycle after acceptance. Back-to-back accepts every cycle.
- **Memory latency.** mem_req rises the cycle after acceptance. With mem_ack in cycle k after that (k≥0), wb_valid is asserted in cycle k+1. Minimum load-to-write-back is 2 cycles.
- **Ack in the cycle mem_req first rises** is legal (zero-wait memory).
- **Simultaneous jump and load.** pc_load fires the cycle after acceptance; the load still completes. Flushing younger instructions is upstream's job.
- **mem_ack while IDLE** is ignored.

## Configuration
- **MEM_TIMEOUT_EN defined:** an 8-bit counter clears on entering WAIT and increments each WAIT cycle without ack. When it reaches TIMEOUT_CYCLES:
  - go to IDLE and drop mem_req;
  - emit wb_valid=1 with wb_wr=0;
  - set mem_err=1. mem_err clears only on reset.
- **Undefined:** no counter; WAIT lasts indefinitely; mem_err is constant 0.

## Test plan
- **Reset:** hold reset_n=0 mid-WAIT with mem_req=1 -> all outputs 0 immediately; after release, stall_o=0 with valid_in=0.
- **ALU op:** valid_in, WRMem=1, rdOut=2, acOutValue=0x3C -> next cycle wb_valid=1, wb_rd=2, wb_data=0x3C, stall_o never 1.
- **Load with 3-cycle ack delay:**
  - stimulus: RMMem=1, acOutValue=0x10, mem_rdata=0xA5;
  - mem_req=1 with addr 0x10, we=0 for 3 cycles plus the ack cycle;
  - stall_o high throughout;
  - wb_data=0xA5 the cycle after ack.
- **Store with zero-wait ack:** WMMem=1, rs=0x7E, acOutValue=0x20 -> one cycle of mem_req/mem_we with wdata 0x7E; wb_wr=0; next bundle accepted two cycles after the first.
- **Conditional jump:**
  - JCMem=1, NEQMem=0, zeroOut=1, ulaJumpOut=0x44 -> pc_load pulse, pc_target=0x44;
  - repeat with zeroOut=0 -> no pulse;
  - NEQMem=1, zeroOut=0 -> pulse.
- **MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4:** load with no ack -> mem_req drops after 4 WAIT cycles; wb_valid=1, wb_wr=0; mem_err=1 and stays set.
